throw_power_ctrl: RTL and testbench

- Parametrised successor to the fixed two-player, 5-bit throw logic.
- Owns the whole local throw sequence: turn gating, mouse-driven power charge (saturating or ping-pong), release-to-fire, and flight hold until the shot resolves.
- Sits in the clk60MHz domain between the mouse path (`left` already buffered to clk60MHz) and the turn manager / board link (`throw_flag`, `power`).

---
 rtl/throw_pkg.sv | 26 ++
 rtl/power_ramp.sv | 93 +++++++++
 rtl/throw_power_ctrl.sv | 173 +++++++++++++++++
 tb/tb_throw_power_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/throw_pkg.sv
// Shared types and helpers for the local throw sequence (throw_power_ctrl, power_ramp).
package throw_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        CHARGE = 3'd2,
        FIRE   = 3'd3,
        FLIGHT = 3'd4
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // Player-id width; a single-player build still needs one bit.
    function automatic int pid_w(input int players);
        if (players > 1) begin
            return $clog2(players);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/power_ramp.sv
// Throw power ramp: STEP_DIV prescaler driving an up/down counter that either
// saturates at full scale or bounces between the limits (PINGPONG).
module power_ramp
    import throw_pkg::*;
#(
    parameter int PWR_W    = 5,
    parameter int STEP_DIV = 1_000_000,
    parameter int PINGPONG = 1
) (
    input  logic             clk60MHz,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [PWR_W-1:0] power,
    output logic             step
);

    localparam int               CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PWR_W-1:0] PWR_MAX  = {PWR_W{1'b1}};
    localparam logic [PWR_W-1:0] PWR_ONE  = PWR_W'(1'b1);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PWR_W-1:0] power_q, power_d;
    dir_t             dir_q,   dir_d;
    logic             step_q,  step_d;

    // Next-state for prescaler, power value and ramp direction.
    always_comb begin
        cnt_d   = cnt_q;
        power_d = power_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            power_d = '0;
            dir_d   = UP;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (dir_q)
                    UP: begin
                        if (power_q != PWR_MAX) begin
                            power_d = power_q + PWR_ONE;
                        end else if (PINGPONG != 0) begin
                            power_d = PWR_MAX - PWR_ONE;
                            dir_d   = DOWN;
                        end else begin
                            power_d = PWR_MAX;
                        end
                    end
                    DOWN: begin
                        if (power_q != '0) begin
                            power_d = power_q - PWR_ONE;
                        end else begin
                            power_d = PWR_ONE;
                            dir_d   = UP;
                        end
                    end
                    default: begin
                        power_d = power_q;
                        dir_d   = UP;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Ramp state registers.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            cnt_q   <= '0;
            power_q <= '0;
            dir_q   <= UP;
            step_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            power_q <= power_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    assign power = power_q;
    assign step  = step_q;

endmodule

// File: rtl/throw_power_ctrl.sv
// Local throw sequencer: turn gating, power charge, release-to-fire, flight hold.
// Define THROW_FLIGHT_TIMEOUT_EN to add the FLIGHT watchdog (flight_timeout).
module throw_power_ctrl
    import throw_pkg::*;
#(
    parameter int  PLAYERS   = 2,
    parameter int  PWR_W     = 5,
    parameter int  STEP_DIV  = 1_000_000,
    parameter int  PINGPONG  = 1,
    parameter int  FLIGHT_TO = 600_000_000,
    localparam int PID_W     = pid_w(PLAYERS)
) (
    input  logic             clk60MHz,
    input  logic             rst,
    input  logic             left,
    input  logic [PID_W-1:0] current_player,
    input  logic [PID_W-1:0] turn,
    input  logic             end_throw,
    output logic [PWR_W-1:0] power,
    output logic             throw_flag,
    output logic             busy,
    output logic             flight_timeout
);

    if (STEP_DIV < 1) begin : g_bad_step_div
        $error("STEP_DIV must be at least 1");
    end
    if (FLIGHT_TO < 2) begin : g_bad_flight_to
        $error("FLIGHT_TO must be at least 2");
    end

    state_t           state_q, state_d;
    logic             throw_flag_q, throw_flag_d;
    logic             busy_q, busy_d;
    logic             my_turn_s;
    logic             ramp_clear_s;
    logic             ramp_enable_s;
    logic [PWR_W-1:0] ramp_power_s;
    logic             unused_step_s;
    logic             expire_s;

    assign my_turn_s = (turn == current_player);

    power_ramp #(
        .PWR_W    (PWR_W),
        .STEP_DIV (STEP_DIV),
        .PINGPONG (PINGPONG)
    ) u_ramp (
        .clk60MHz (clk60MHz),
        .rst      (rst),
        .clear    (ramp_clear_s),
        .enable   (ramp_enable_s),
        .power    (ramp_power_s),
        .step     (unused_step_s)
    );

    // Throw FSM; the ramp only advances while the button is held on our turn,
    // so a release coinciding with a step fires the pre-step value.
    always_comb begin
        state_d       = state_q;
        throw_flag_d  = 1'b0;
        ramp_clear_s  = 1'b0;
        ramp_enable_s = 1'b0;
        case (state_q)
            IDLE: begin
                ramp_clear_s = 1'b1;
                if (my_turn_s && !left) begin
                    state_d = READY;
                end else begin
                    state_d = IDLE;
                end
            end
            READY: begin
                ramp_clear_s = 1'b1;
                if (!my_turn_s) begin
                    state_d = IDLE;
                end else if (left) begin
                    state_d = CHARGE;
                end else begin
                    state_d = READY;
                end
            end
            CHARGE: begin
                if (!my_turn_s) begin
                    state_d      = IDLE;
                    ramp_clear_s = 1'b1;
                end else if (!left) begin
                    if (ramp_power_s != '0) begin
                        state_d      = FIRE;
                        throw_flag_d = 1'b1;
                    end else begin
                        state_d      = READY;
                        ramp_clear_s = 1'b1;
                    end
                end else begin
                    state_d       = CHARGE;
                    ramp_enable_s = 1'b1;
                end
            end
            FIRE: begin
                state_d = FLIGHT;
            end
            FLIGHT: begin
                if (end_throw || expire_s) begin
                    state_d      = IDLE;
                    ramp_clear_s = 1'b1;
                end else begin
                    state_d = FLIGHT;
                end
            end
            default: begin
                state_d      = IDLE;
                ramp_clear_s = 1'b1;
            end
        endcase
        busy_d = (state_d == CHARGE) || (state_d == FIRE) || (state_d == FLIGHT);
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q      <= IDLE;
            throw_flag_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            throw_flag_q <= throw_flag_d;
            busy_q       <= busy_d;
        end
    end

`ifdef THROW_FLIGHT_TIMEOUT_EN
    localparam int              FT_W    = $clog2(FLIGHT_TO);
    localparam logic [FT_W-1:0] FT_LAST = FT_W'(FLIGHT_TO - 1);
    localparam logic [FT_W-1:0] FT_ONE  = FT_W'(1'b1);

    logic [FT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic            flight_timeout_q, flight_timeout_d;

    assign expire_s = (state_q == FLIGHT) && (flt_cnt_q == FT_LAST);

    // Watchdog counts from the FIRE cycle so expiry lands FLIGHT_TO cycles after the fire pulse.
    always_comb begin
        if ((state_q == FIRE) || (state_q == FLIGHT)) begin
            flt_cnt_d = flt_cnt_q + FT_ONE;
        end else begin
            flt_cnt_d = '0;
        end
        flight_timeout_d = expire_s && !end_throw;
    end

    // Watchdog registers.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            flt_cnt_q        <= '0;
            flight_timeout_q <= 1'b0;
        end else begin
            flt_cnt_q        <= flt_cnt_d;
            flight_timeout_q <= flight_timeout_d;
        end
    end

    assign flight_timeout = flight_timeout_q;
`else
    assign expire_s       = 1'b0;
    assign flight_timeout = 1'b0;
`endif

    assign power      = ramp_power_s;
    assign throw_flag = throw_flag_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_throw_power_ctrl.sv
// Directed bench for throw_power_ctrl (PWR_W=3, STEP_DIV=4, PLAYERS=2, player 1);
// a second instance with PINGPONG=0 shares all inputs.
module tb_throw_power_ctrl;

    logic       clk60MHz;
    logic       rst;
    logic       left;
    logic [0:0] current_player;
    logic [0:0] turn;
    logic       end_throw;
    logic [2:0] power,      power_sat;
    logic       throw_flag, throw_flag_sat;
    logic       busy,       busy_sat;
    logic       flight_timeout, flight_timeout_sat;

    int tests_run    = 0;
    int tests_failed = 0;

    throw_power_ctrl #(
        .PLAYERS(2), .PWR_W(3), .STEP_DIV(4), .PINGPONG(1), .FLIGHT_TO(20)
    ) dut (
        .clk60MHz(clk60MHz), .rst(rst), .left(left),
        .current_player(current_player), .turn(turn), .end_throw(end_throw),
        .power(power), .throw_flag(throw_flag), .busy(busy),
        .flight_timeout(flight_timeout)
    );

    throw_power_ctrl #(
        .PLAYERS(2), .PWR_W(3), .STEP_DIV(4), .PINGPONG(0), .FLIGHT_TO(20)
    ) dut_sat (
        .clk60MHz(clk60MHz), .rst(rst), .left(left),
        .current_player(current_player), .turn(turn), .end_throw(end_throw),
        .power(power_sat), .throw_flag(throw_flag_sat), .busy(busy_sat),
        .flight_timeout(flight_timeout_sat)
    );

    initial clk60MHz = 1'b0;
    always #5 clk60MHz = ~clk60MHz;

    // One clock; outputs are then read 1 time unit after the edge.
    task automatic step();
        @(posedge clk60MHz);
        #1;
    endtask

    // From READY: press for n cycles (first one enters CHARGE), then release.
    task automatic press_and_release(input int n);
        left = 1'b1;
        repeat (n) step();
        left = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; left = 1'b0; turn = 1'b0; current_player = 1'b1; end_throw = 1'b0;
        step(); step();
        rst = 1'b0;
        tests_run++;
        if (power !== 3'd0 || throw_flag !== 1'b0 || busy !== 1'b0 || flight_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: power=%0d flag=%b busy=%b tmo=%b, required 0 0 0 0",
                     power, throw_flag, busy, flight_timeout);
        end
    endtask

    task automatic test_basic_fire();
        turn = 1'b1; left = 1'b0;
        step();
        left = 1'b1;
        repeat (14) step();
        tests_run++;
        if (power !== 3'd3 || busy !== 1'b1 || throw_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_charge: power=%0d busy=%b flag=%b, required 3 1 0", power, busy, throw_flag);
        end
        left = 1'b0;
        step();
        tests_run++;
        if (throw_flag !== 1'b1 || power !== 3'd3) begin
            tests_failed++;
            $display("FAIL basic_fire: flag=%b power=%0d, required 1 3", throw_flag, power);
        end
        step();
        tests_run++;
        if (throw_flag !== 1'b0 || busy !== 1'b1 || power !== 3'd3) begin
            tests_failed++;
            $display("FAIL basic_flight: flag=%b busy=%b power=%0d, required 0 1 3", throw_flag, busy, power);
        end
        left = 1'b1; turn = 1'b0;
        repeat (5) step();
        tests_run++;
        if (busy !== 1'b1 || power !== 3'd3 || throw_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_hold: busy=%b power=%0d flag=%b, required 1 3 0", busy, power, throw_flag);
        end
        left = 1'b0; turn = 1'b1; end_throw = 1'b1;
        step();
        end_throw = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || power !== 3'd0) begin
            tests_failed++;
            $display("FAIL basic_end: busy=%b power=%0d, required 0 0", busy, power);
        end
    endtask

    task automatic test_pingpong();
        int         pp_seq[9]  = '{1, 2, 3, 4, 5, 6, 7, 6, 5};
        int         sat_seq[9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
        logic [2:0] exp_pp, exp_sat;
        turn = 1'b1; left = 1'b0;
        step();
        left = 1'b1;
        step();
        for (int k = 1; k <= 39; k++) begin
            step();
            exp_pp  = (k < 4) ? 3'd0 : 3'(pp_seq[k / 4 - 1]);
            exp_sat = (k < 4) ? 3'd0 : 3'(sat_seq[k / 4 - 1]);
            tests_run++;
            if (power !== exp_pp || power_sat !== exp_sat) begin
                tests_failed++;
                $display("FAIL pingpong k=%0d: power=%0d sat=%0d, required %0d %0d",
                         k, power, power_sat, exp_pp, exp_sat);
            end
        end
        left = 1'b0;
        step();
        tests_run++;
        if (throw_flag !== 1'b1 || power !== 3'd5 || throw_flag_sat !== 1'b1 || power_sat !== 3'd7) begin
            tests_failed++;
            $display("FAIL pingpong_fire: flag=%b power=%0d sat_flag=%b sat=%0d, required 1 5 1 7",
                     throw_flag, power, throw_flag_sat, power_sat);
        end
        step();
        end_throw = 1'b1;
        step();
        end_throw = 1'b0;
    endtask

    task automatic test_turn_gating();
        turn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            left = i[0];
            step();
            tests_run++;
            if (throw_flag !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL gate_other i=%0d: flag=%b busy=%b, required 0 0", i, throw_flag, busy);
            end
        end
        left = 1'b1;
        step();
        turn = 1'b1;
        repeat (6) step();
        tests_run++;
        if (busy !== 1'b0 || power !== 3'd0) begin
            tests_failed++;
            $display("FAIL gate_held: busy=%b power=%0d, required 0 0", busy, power);
        end
        left = 1'b0;
        step();
        left = 1'b1;
        step();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL gate_repress: busy=%b, required 1", busy);
        end
    endtask

    task automatic test_abort();
        repeat (4) step();
        tests_run++;
        if (power !== 3'd1) begin
            tests_failed++;
            $display("FAIL abort_charge: power=%0d, required 1", power);
        end
        turn = 1'b0; left = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || power !== 3'd0 || throw_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_turn: busy=%b power=%0d flag=%b, required 0 0 0", busy, power, throw_flag);
        end
        step();
        tests_run++;
        if (throw_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_turn_flag: flag=%b, required 0", throw_flag);
        end
        turn = 1'b1;
        step();
        left = 1'b1;
        step(); step();
        left = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || throw_flag !== 1'b0 || power !== 3'd0) begin
            tests_failed++;
            $display("FAIL abort_zero: busy=%b flag=%b power=%0d, required 0 0 0", busy, throw_flag, power);
        end
        left = 1'b1;
        step();
        tests_run++;
        if (busy !== 1'b1 || throw_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_zero_ready: busy=%b flag=%b, required 1 0", busy, throw_flag);
        end
        left = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_flight();
        press_and_release(5);
        tests_run++;
        if (throw_flag !== 1'b1 || power !== 3'd1) begin
            tests_failed++;
            $display("FAIL rst_fire: flag=%b power=%0d, required 1 1", throw_flag, power);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (power !== 3'd0 || throw_flag !== 1'b0 || busy !== 1'b0 || flight_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_flight: power=%0d flag=%b busy=%b tmo=%b, required 0 0 0 0",
                     power, throw_flag, busy, flight_timeout);
        end
        end_throw = 1'b1;
        step();
        end_throw = 1'b0;
        step();
        tests_run++;
        if (power !== 3'd0 || throw_flag !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_late_end: power=%0d flag=%b busy=%b, required 0 0 0", power, throw_flag, busy);
        end
    endtask

    task automatic test_flight_watchdog();
        int cycles;
        turn = 1'b1; left = 1'b0;
        step();
        press_and_release(5);
        cycles = 0;
`ifdef THROW_FLIGHT_TIMEOUT_EN
        while (flight_timeout !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        tests_run++;
        if (cycles !== 20) begin
            tests_failed++;
            $display("FAIL wd_expiry: pulse after %0d cycles, required 20", cycles);
        end
        step();
        tests_run++;
        if (flight_timeout !== 1'b0 || busy !== 1'b0 || power !== 3'd0) begin
            tests_failed++;
            $display("FAIL wd_after: tmo=%b busy=%b power=%0d, required 0 0 0", flight_timeout, busy, power);
        end
        press_and_release(5);
        repeat (19) step();
        end_throw = 1'b1;
        step();
        end_throw = 1'b0;
        tests_run++;
        if (flight_timeout !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_end_wins: tmo=%b busy=%b, required 0 0", flight_timeout, busy);
        end
`else
        repeat (30) begin
            step();
            cycles = cycles + (flight_timeout === 1'b1 ? 1 : 0) + (busy === 1'b1 ? 0 : 1);
        end
        tests_run++;
        if (cycles !== 0) begin
            tests_failed++;
            $display("FAIL wd_off: %0d cycles with timeout or not busy, required 0", cycles);
        end
        end_throw = 1'b1;
        step();
        end_throw = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || power !== 3'd0) begin
            tests_failed++;
            $display("FAIL wd_off_end: busy=%b power=%0d, required 0 0", busy, power);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_fire();
        test_pingpong();
        test_turn_gating();
        test_abort();
        test_reset_mid_flight();
        test_flight_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
